// File: rtl/tqvp_console_pkg.sv
// Shared geometry, control codes and state encoding for the console writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tqvp_console_pkg;

    localparam int NUM_ROWS  = 3;
    localparam int NUM_COLS  = 10;
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;

    localparam int ADDR_W = 5;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 4;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SCROLL_COPY  = 2'd1,
        SCROLL_CLEAR = 2'd2,
        CLEAR_ALL    = 2'd3
    } state_t;

    // Linear text-buffer address of a cursor position, row-major, kept in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(NUM_COLS) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/tqvp_console_writer.sv
// Byte-stream to text-buffer writer with cursor, control codes, scroll and clear.
// Latency: a write caused by an accepted byte appears on buf_* the following cycle.
// Backpressure: in_ready is high only in IDLE; scroll/clear sequences hold the stream off.
module tqvp_console_writer
    import tqvp_console_pkg::*;
#(
    parameter logic [1:0] CLEAR_COLOR = 2'b00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic [1:0]        in_color,
    output logic              in_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [8:0]        buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [8:0]        buf_rdata,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] COPY_FIRST    = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [ADDR_W-1:0] LAST_CHAR     = ADDR_W'(NUM_CHARS - 1);
    localparam logic [8:0]        BLANK         = {CLEAR_COLOR, CH_SPACE[6:0]};

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [ADDR_W-1:0]   cnt;

    logic accept;
    logic printable;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid & in_ready;
    assign printable  = (in_data >= 8'h20) && (in_data <= 8'h7E);
    // The copy counter doubles as the read pointer so the next cycle can write what it fetched.
    assign buf_raddr  = cnt;
    assign cursor_row = row;
    assign cursor_col = col;

    // Cursor, byte decode, scroll/clear sequencing and registered write port in one FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
        end else begin
            buf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            buf_we    <= 1'b1;
                            buf_waddr <= cell_addr(row, col);
                            buf_wdata <= {in_color, in_data[6:0]};
                            if (col == LAST_COL) begin
                                col <= '0;
                                if (row == LAST_ROW) begin
                                    // Row stays on the last line; the scroll makes room.
                                    state <= SCROLL_COPY;
                                    cnt   <= COPY_FIRST;
                                end else begin
                                    row <= row + ROW_W'(1);
                                end
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end else begin
                            case (in_data)
                                CH_LF: begin
                                    col <= '0;
                                    if (row == LAST_ROW) begin
                                        state <= SCROLL_COPY;
                                        cnt   <= COPY_FIRST;
                                    end else begin
                                        row <= row + ROW_W'(1);
                                    end
                                end
                                CH_CR: begin
                                    col <= '0;
                                end
                                CH_BS: begin
                                    if (col != '0) begin
                                        col       <= col - COL_W'(1);
                                        buf_we    <= 1'b1;
                                        buf_waddr <= cell_addr(row, col - COL_W'(1));
                                        buf_wdata <= BLANK;
                                    end
                                end
                                CH_FF: begin
                                    row   <= '0;
                                    col   <= '0;
                                    cnt   <= '0;
                                    state <= CLEAR_ALL;
                                end
                                default: begin
                                    // Unknown control codes are consumed without effect.
                                end
                            endcase
                        end
                    end
                end

                SCROLL_COPY: begin
                    // buf_rdata reflects buf_raddr == cnt this cycle; store it one row up.
                    buf_we    <= 1'b1;
                    buf_waddr <= cnt - COPY_FIRST;
                    buf_wdata <= buf_rdata;
                    if (cnt == LAST_CHAR) begin
                        state <= SCROLL_CLEAR;
                        cnt   <= LAST_ROW_BASE;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end

                SCROLL_CLEAR, CLEAR_ALL: begin
                    // Both sequences blank cells from cnt up to the last character.
                    buf_we    <= 1'b1;
                    buf_waddr <= cnt;
                    buf_wdata <= BLANK;
                    if (cnt == LAST_CHAR) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_console_writer.sv
// Self-checking bench for the console writer with a behavioural text-buffer model.
// Latency: writes are expected on buf_* the cycle after byte acceptance.
// Backpressure: bytes are only presented once in_ready is observed high.
module tb_tqvp_console_writer;
    import tqvp_console_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_color;
    logic        in_ready;
    logic        buf_we;
    logic [4:0]  buf_waddr;
    logic [8:0]  buf_wdata;
    logic [4:0]  buf_raddr;
    logic [8:0]  buf_rdata;
    logic [1:0]  cursor_row;
    logic [3:0]  cursor_col;
    logic        busy;

    tqvp_console_writer #(.CLEAR_COLOR(2'b00)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_color   (in_color),
        .in_ready   (in_ready),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .buf_raddr  (buf_raddr),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Text buffer: combinational read, commit on the edge where buf_we is high.
    logic [8:0] mem [0:31];
    assign buf_rdata = mem[buf_raddr];
    initial for (int i = 0; i < 32; i++) mem[i] <= 9'h000;
    always @(posedge clk) if (buf_we) mem[buf_waddr] <= buf_wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] exp_q [$];
    logic [13:0] mon_e;
    logic [8:0]  shadow [0:NUM_CHARS-1];
    int m_row, m_col;

    // Scoreboard: every write strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!reset && buf_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got addr=%0d data=%h, expected no write", buf_waddr, buf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({buf_waddr, buf_wdata} !== mon_e) begin
                    n_err++;
                    $display("FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                             buf_waddr, buf_wdata, mon_e[13:9], mon_e[8:0]);
                end
            end
        end
    end

    task automatic push_w(input int a, input logic [8:0] d);
        exp_q.push_back({5'(a), d});
        shadow[a] = d;
    endtask

    task automatic model_scroll();
        for (int a = NUM_COLS; a < NUM_CHARS; a++) push_w(a - NUM_COLS, shadow[a]);
        for (int a = (NUM_ROWS - 1) * NUM_COLS; a < NUM_CHARS; a++) push_w(a, 9'h020);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic [1:0] c);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_w(m_row * NUM_COLS + m_col, {c, b[6:0]});
            if (m_col == NUM_COLS - 1) begin
                m_col = 0;
                if (m_row == NUM_ROWS - 1) model_scroll();
                else m_row++;
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            if (m_row == NUM_ROWS - 1) model_scroll();
            else m_row++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_w(m_row * NUM_COLS + m_col, 9'h020);
            end
        end else if (b == 8'h0C) begin
            for (int a = 0; a < NUM_CHARS; a++) push_w(a, 9'h020);
            m_row = 0;
            m_col = 0;
        end
    endtask

    // Present one byte once in_ready is seen; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic [1:0] c);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout in_ready=%b, expected 1 within 200 cycles", in_ready);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            in_color = c;
            model_byte(b, c);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_cmp++;
        if (busy || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wait_idle busy=%b pending=%0d, expected busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        n_cmp++;
        if (cursor_row !== 2'(r) || cursor_col !== 4'(c)) begin
            n_err++;
            $display("FAIL %s cursor got (%0d,%0d), expected (%0d,%0d)", name, cursor_row, cursor_col, r, c);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_row = 0;
        m_col = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b0 || buf_waddr !== 5'd0 || buf_wdata !== 9'h000) begin
            n_err++;
            $display("FAIL reset_bufout got we=%b addr=%0d data=%h, expected 0/0/000", buf_we, buf_waddr, buf_wdata);
        end
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state got busy=%b in_ready=%b, expected 0/1", busy, in_ready);
        end
        check_cursor("reset", 0, 0);
    endtask

    task automatic test_first_char();
        send_byte(8'h41, 2'b10);
        @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b1 || buf_waddr !== 5'd0 || buf_wdata !== 9'h141) begin
            n_err++;
            $display("FAIL first_char got we=%b addr=%0d data=%h, expected 1/0/141", buf_we, buf_waddr, buf_wdata);
        end
        check_cursor("first_char", 0, 1);
        wait_idle();
    endtask

    task automatic test_row_wrap();
        do_reset();
        for (int i = 0; i < NUM_COLS; i++) begin
            send_byte(8'h61 + 8'(i), 2'(i));
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL row_wrap_busy char %0d busy=%b, expected 0", i, busy);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b1 || buf_waddr !== 5'd9) begin
            n_err++;
            $display("FAIL row_wrap_last got we=%b addr=%0d, expected 1/9", buf_we, buf_waddr);
        end
        check_cursor("row_wrap", 1, 0);
        wait_idle();
    endtask

    task automatic test_scroll();
        int n = 0;
        for (int i = 0; i < 19; i++) send_byte(8'h4B + 8'(i), 2'(i + 1));
        check_cursor("scroll_pre", 2, 9);
        send_byte(8'h5A, 2'b00);
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n !== 30 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL scroll_busy got %0d cycles in_ready=%b, expected 30 cycles in_ready=1", n, in_ready);
        end
        check_cursor("scroll_post", 2, 0);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scroll_pending got %0d writes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_control();
        logic [7:0] junk [3];
        junk[0] = 8'h07;
        junk[1] = 8'h7F;
        junk[2] = 8'h1B;
        send_byte(8'h0C, 2'b00);
        wait_idle();
        check_cursor("ff", 0, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 2'b01);
        check_cursor("pre_lf", 0, 4);
        send_byte(8'h0A, 2'b00);
        @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b0) begin
            n_err++;
            $display("FAIL lf_nowrite got we=%b, expected 0", buf_we);
        end
        check_cursor("lf", 1, 0);
        send_byte(8'h0D, 2'b00);
        check_cursor("cr", 1, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(junk[i], 2'b11);
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || in_ready !== 1'b1 || buf_we !== 1'b0) begin
                n_err++;
                $display("FAIL drop_%h got busy=%b in_ready=%b we=%b, expected 0/1/0", junk[i], busy, in_ready, buf_we);
            end
            check_cursor("drop", 1, 0);
        end
    endtask

    task automatic test_backspace();
        send_byte(8'h20, 2'b10);
        send_byte(8'h7E, 2'b11);
        send_byte(8'h41, 2'b01);
        check_cursor("pre_bs", 1, 3);
        send_byte(8'h08, 2'b11);
        @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b1 || buf_waddr !== 5'd12 || buf_wdata !== 9'h020) begin
            n_err++;
            $display("FAIL bs_write got we=%b addr=%0d data=%h, expected 1/12/020", buf_we, buf_waddr, buf_wdata);
        end
        check_cursor("bs", 1, 2);
        send_byte(8'h0C, 2'b00);
        wait_idle();
        send_byte(8'h08, 2'b00);
        @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b0) begin
            n_err++;
            $display("FAIL bs_col0 got we=%b, expected 0", buf_we);
        end
        check_cursor("bs_col0", 0, 0);
    endtask

    task automatic test_lf_scroll();
        send_byte(8'h41, 2'b01);
        send_byte(8'h0A, 2'b00);
        send_byte(8'h42, 2'b10);
        send_byte(8'h0A, 2'b00);
        send_byte(8'h43, 2'b11);
        check_cursor("lf_last_row", 2, 1);
        send_byte(8'h0A, 2'b00);
        wait_idle();
        check_cursor("lf_scroll", 2, 0);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h0A, 2'b00);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (buf_we !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_scroll got we=%b busy=%b, expected 1/1", buf_we, busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (buf_we !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got we=%b busy=%b, expected 0/0", buf_we, busy);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || buf_we !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset got in_ready=%b we=%b, expected 1/0", in_ready, buf_we);
        end
        check_cursor("post_reset", 0, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_color = 2'b00;
        m_row    = 0;
        m_col    = 0;
        for (int i = 0; i < NUM_CHARS; i++) shadow[i] = 9'h000;
        test_reset();
        test_first_char();
        test_row_wrap();
        test_scroll();
        test_control();
        test_backspace();
        test_lf_scroll();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
